// File: rtl/serie_paralelo_rx.sv
// Serial-to-parallel receiver: finds byte alignment on COM symbols, goes ACTIVE after
// N_COM consecutive aligned COMs, then emits one byte per 8 clocks.
module serie_paralelo_rx #(
    parameter logic [7:0]  COM   = 8'hBC,
    parameter logic [7:0]  IDL   = 8'h7C,
    parameter int unsigned N_COM = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_tick,
    output logic       active
);

    localparam int unsigned CW = (N_COM < 2) ? 1 : $clog2(N_COM + 1);

    typedef enum logic [1:0] {
        StHunt,
        StAlign,
        StActive
    } state_t;

    state_t          state;
    logic [6:0]      sr;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   com_cnt;
    logic [7:0]      w;
    logic            is_com;
    logic            last_com;

    // Only the 7 older bits need storing; the current line bit completes the window.
    assign w        = {sr, data_in};
    assign is_com   = (w == COM);
    assign last_com = ((32'(com_cnt) + 32'd1) == N_COM);

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state     <= StHunt;
            sr        <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            byte_tick <= 1'b0;
            active    <= 1'b0;
        end else begin
            sr        <= w[6:0];
            byte_tick <= 1'b0;
            case (state)
                StHunt: begin
                    bit_cnt <= '0;
                    if (is_com) begin
                        com_cnt <= CW'(1);
                        if (N_COM == 1) begin
                            state  <= StActive;
                            active <= 1'b1;
                        end else begin
                            state <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (is_com && last_com) begin
                            state   <= StActive;
                            active  <= 1'b1;
                            com_cnt <= CW'(N_COM);
                        end else if (is_com) begin
                            com_cnt <= com_cnt + CW'(1);
                        end else begin
                            // A COM straddling a non-boundary does not count; rehunt bitwise.
                            state   <= StHunt;
                            com_cnt <= '0;
                        end
                    end
                end
                StActive: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        data_out  <= w;
                        valid_out <= !is_com && (w != IDL);
                        byte_tick <= 1'b1;
                    end
                end
                default: begin
                    state <= StHunt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serie_paralelo_rx.sv
// Bench for serie_paralelo_rx: directed scenarios plus randomized streams against a
// bit-history reference model; a second instance covers N_COM=1.
module tb_serie_paralelo_rx;

    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic       data1   = 1'b0;
    logic [7:0] data_out, data_out1;
    logic       valid_out, valid_out1, byte_tick, byte_tick1, active, active1;

    int n_tests = 0;
    int n_fail  = 0;
    int ticks   = 0;
    int ticks1  = 0;

    // Reference model state (N_COM = 4)
    logic [7:0] m_win;
    int         m_phase;
    int         m_coms;
    bit         m_linked;
    logic [7:0] e_data;
    bit         e_valid;
    int         e_ticks;

    always #5 clk_32f = ~clk_32f;

    serie_paralelo_rx #(.COM(COM), .IDL(IDL), .N_COM(4)) dut (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .byte_tick(byte_tick), .active(active)
    );

    serie_paralelo_rx #(.COM(COM), .IDL(IDL), .N_COM(1)) dut1 (
        .clk_32f(clk_32f), .reset_L(reset_L), .data_in(data1),
        .data_out(data_out1), .valid_out(valid_out1), .byte_tick(byte_tick1), .active(active1)
    );

    task automatic m_reset();
        m_win = '0; m_phase = -1; m_coms = 0; m_linked = 0;
        e_data = '0; e_valid = 0; e_ticks = 0;
    endtask

    // Model: hunt every bit for COM; once anchored, judge every 8th bit after the anchor.
    task automatic m_step(input bit b);
        m_win = {m_win[6:0], b};
        if (m_phase < 0) begin
            if (m_win == COM) begin
                m_phase = 0; m_coms = 1; m_linked = 0;
            end
        end else begin
            m_phase++;
            if (m_phase % 8 == 0) begin
                if (m_linked) begin
                    e_data = m_win;
                    e_valid = (m_win != COM) && (m_win != IDL);
                    e_ticks++;
                end else if (m_win == COM) begin
                    m_coms++;
                    if (m_coms == 4) m_linked = 1;
                end else begin
                    m_phase = -1; m_coms = 0;
                end
            end
        end
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        m_step(b);
        #1;
        if (byte_tick) ticks++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_bit1(input bit b);
        @(negedge clk_32f);
        data1 = b;
        @(posedge clk_32f);
        #1;
        if (byte_tick1) ticks1++;
    endtask

    task automatic send_byte1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit1(b[i]);
    endtask

    task automatic apply_reset();
        @(negedge clk_32f);
        reset_L = 1'b0;
        m_reset();
        ticks = 0; ticks1 = 0;
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", data_out); end
        n_tests++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        n_tests++; if (byte_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %b want 0", byte_tick); end
        n_tests++; if ({active, active1} !== 2'b00) begin n_fail++; $display("FAIL reset_active: got %b want 00", {active, active1}); end
        m_reset();
        @(negedge clk_32f);
        reset_L = 1'b1;
    endtask

    task automatic test_aligned();
        logic [7:0] c;
        c = COM;
        apply_reset();
        repeat (3) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(c[i]);
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL aligned_pre_active: got %b want 0", active); end
        send_bit(c[0]);
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL aligned_active_32: got %b want 1", active); end
        n_tests++; if (ticks !== 0) begin n_fail++; $display("FAIL aligned_no_tick_in_align: got %0d want 0", ticks); end
        send_byte(8'hA5);
        n_tests++; if (data_out !== 8'hA5 || valid_out !== 1'b1 || byte_tick !== 1'b1) begin
            n_fail++; $display("FAIL aligned_a5: got %h/%b/%b want a5/1/1", data_out, valid_out, byte_tick); end
        send_bit(1'b0);
        n_tests++; if (byte_tick !== 1'b0 || data_out !== 8'hA5) begin
            n_fail++; $display("FAIL aligned_hold: got %h/%b want a5/0", data_out, byte_tick); end
        for (int i = 6; i >= 0; i--) send_bit(i >= 2 && i <= 5);
        n_tests++; if (data_out !== 8'h3C || valid_out !== 1'b1 || ticks !== 2) begin
            n_fail++; $display("FAIL aligned_3c: got %h/%b ticks %0d want 3c/1 ticks 2", data_out, valid_out, ticks); end
    endtask

    task automatic test_offset();
        apply_reset();
        repeat (3) send_bit(1'b0);
        repeat (4) send_byte(COM);
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL offset_active: got %b want 1", active); end
        send_byte(IDL);
        n_tests++; if (data_out !== IDL || valid_out !== 1'b0 || byte_tick !== 1'b1) begin
            n_fail++; $display("FAIL offset_idl: got %h/%b/%b want 7c/0/1", data_out, valid_out, byte_tick); end
        send_byte(8'h01);
        n_tests++; if (data_out !== 8'h01 || valid_out !== 1'b1 || ticks !== 2) begin
            n_fail++; $display("FAIL offset_01: got %h/%b ticks %0d want 01/1 ticks 2", data_out, valid_out, ticks); end
    endtask

    task automatic test_abort();
        apply_reset();
        send_byte(COM); send_byte(COM); send_byte(8'h55);
        repeat (3) send_byte(COM);
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL abort_not_active: got %b want 0", active); end
        send_byte(COM);
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL abort_active: got %b want 1", active); end
        send_byte(8'hF0);
        n_tests++; if (data_out !== 8'hF0 || valid_out !== 1'b1) begin
            n_fail++; $display("FAIL abort_f0: got %h/%b want f0/1", data_out, valid_out); end
    endtask

    task automatic test_com_midstream();
        send_byte(8'h11);
        n_tests++; if (data_out !== 8'h11 || valid_out !== 1'b1) begin
            n_fail++; $display("FAIL mid_11: got %h/%b want 11/1", data_out, valid_out); end
        send_byte(COM);
        n_tests++; if (data_out !== COM || valid_out !== 1'b0 || active !== 1'b1) begin
            n_fail++; $display("FAIL mid_bc: got %h/%b/%b want bc/0/1", data_out, valid_out, active); end
        send_byte(8'h22);
        n_tests++; if (data_out !== 8'h22 || valid_out !== 1'b1) begin
            n_fail++; $display("FAIL mid_22: got %h/%b want 22/1", data_out, valid_out); end
    endtask

    task automatic test_mid_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        #1;
        reset_L = 1'b0;
        m_reset();
        #1;
        n_tests++; if ({data_out, valid_out, byte_tick, active} !== 11'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h/%b/%b/%b want 00/0/0/0", data_out, valid_out, byte_tick, active); end
        @(negedge clk_32f);
        reset_L = 1'b1;
        ticks = 0;
        repeat (3) send_byte(COM);
        n_tests++; if (active !== 1'b0) begin n_fail++; $display("FAIL midrst_realign: got %b want 0", active); end
        send_byte(COM);
        n_tests++; if (active !== 1'b1) begin n_fail++; $display("FAIL midrst_active: got %b want 1", active); end
    endtask

    task automatic test_random();
        logic [7:0] b;
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            repeat ($urandom_range(0, 20)) send_bit(1'($urandom));
            repeat (4) send_byte(COM);
            for (int k = 0; k < 16; k++) begin
                case ($urandom_range(0, 5))
                    0: b = COM;
                    1: b = IDL;
                    default: b = 8'($urandom);
                endcase
                if ($urandom_range(0, 7) == 0) send_bit(1'($urandom));
                send_byte(b);
                n_tests++;
                if (data_out !== e_data || valid_out !== e_valid || active !== m_linked || ticks !== e_ticks) begin
                    n_fail++;
                    $display("FAIL random_r%0d_b%0d: got %h/%b/%b ticks %0d want %h/%b/%b ticks %0d",
                             r, k, data_out, valid_out, active, ticks, e_data, e_valid, m_linked, e_ticks);
                end
            end
        end
    endtask

    task automatic test_ncom1();
        logic [7:0] b;
        apply_reset();
        send_byte1(COM);
        n_tests++; if (active1 !== 1'b1) begin n_fail++; $display("FAIL ncom1_active: got %b want 1", active1); end
        send_byte1(8'hC3);
        n_tests++; if (data_out1 !== 8'hC3 || valid_out1 !== 1'b1 || ticks1 !== 1) begin
            n_fail++; $display("FAIL ncom1_c3: got %h/%b ticks %0d want c3/1 ticks 1", data_out1, valid_out1, ticks1); end
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            send_byte1(b);
            n_tests++; if (data_out1 !== b || valid_out1 !== (b != COM && b != IDL) || ticks1 !== k + 2) begin
                n_fail++; $display("FAIL ncom1_rand%0d: got %h/%b ticks %0d want %h ticks %0d", k, data_out1, valid_out1, ticks1, b, k + 2); end
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_offset();
        test_abort();
        test_com_midstream();
        test_mid_reset();
        test_random();
        test_ncom1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
